axi_master_if: RTL and testbench

- Generic AXI master port for accelerator datapaths. Initiator-side counterpart to the SRAM-backed AXI slave interface.
- Accepts one local command at a time (read or write, start address, beat count). Issues the matching INCR burst on the AW/W/B or AR/R channels.
- Streams write data in and read data out through local valid/ready handshakes.
- Reports completion and response status. Attaches to the bus fabric as one of `masters` initiators.

---
 rtl/axi_master_if_if.sv | 83 ++++++++
 rtl/axi_master_if.sv | 168 ++++++++++++++++
 tb/tb_axi_master_if.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_if_if.sv
// rtl/axi_master_if_if.sv - AXI channel bundle between the accelerator master port and the fabric
interface axi_master_if_if #(
    parameter int masters  = 4,
    parameter int width    = 16,
    parameter int id_bits  = 16,
    parameter int b_size   = 3,
    parameter int len_bits = 8
);
    localparam int data_bits = 8 << b_size;
    localparam int strb_bits = 1 << b_size;

    logic [masters-1:0]   AWMASTER;
    logic [id_bits-1:0]   AWID;
    logic [width-1:0]     AWADDR;
    logic [len_bits-1:0]  AWLEN;
    logic [2:0]           AWSIZE;
    logic [1:0]           AWBURST;
    logic [1:0]           AWLOCK;
    logic [3:0]           AWCACHE;
    logic [2:0]           AWPROT;
    logic                 AWVALID;
    logic                 AWREADY;

    logic [masters-1:0]   WMASTER;
    logic [id_bits-1:0]   WID;
    logic [data_bits-1:0] WDATA;
    logic [strb_bits-1:0] WSTRB;
    logic                 WLAST;
    logic                 WVALID;
    logic                 WREADY;

    logic [masters-1:0]   BMASTER;
    logic [id_bits-1:0]   BID;
    logic [1:0]           BRESP;
    logic                 BVALID;
    logic                 BREADY;

    logic [masters-1:0]   ARMASTER;
    logic [id_bits-1:0]   ARID;
    logic [width-1:0]     ARADDR;
    logic [len_bits-1:0]  ARLEN;
    logic [2:0]           ARSIZE;
    logic [1:0]           ARBURST;
    logic [1:0]           ARLOCK;
    logic [3:0]           ARCACHE;
    logic [2:0]           ARPROT;
    logic                 ARVALID;
    logic                 ARREADY;

    logic [masters-1:0]   RMASTER;
    logic [id_bits-1:0]   RID;
    logic [data_bits-1:0] RDATA;
    logic [1:0]           RRESP;
    logic                 RLAST;
    logic                 RVALID;
    logic                 RREADY;

    modport master (
        output AWMASTER, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WMASTER, WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BMASTER, BID, BRESP, BVALID,
        output BREADY,
        output ARMASTER, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RMASTER, RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWMASTER, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WMASTER, WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BMASTER, BID, BRESP, BVALID,
        input  BREADY,
        input  ARMASTER, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RMASTER, RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_master_if.sv
// rtl/axi_master_if.sv - single-outstanding AXI INCR burst master with local command/data streams
module axi_master_if #(
    parameter int masters    = 4,
    parameter int master_num = 0,
    parameter int width      = 16,
    parameter int id_bits    = 16,
    parameter int b_size     = 3,
    parameter int len_bits   = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic                      CMD_WRITE,
    input  logic [width-1:0]          CMD_ADDR,
    input  logic [len_bits-1:0]       CMD_LEN,
    input  logic [(8<<b_size)-1:0]    WD_DATA,
    input  logic [(1<<b_size)-1:0]    WD_STRB,
    input  logic                      WD_VALID,
    output logic                      WD_READY,
    output logic [(8<<b_size)-1:0]    RD_DATA,
    output logic                      RD_LAST,
    output logic                      RD_VALID,
    input  logic                      RD_READY,
    output logic                      DONE,
    output logic                      ERROR,
    axi_master_if_if.master           bus
);
    localparam logic [masters-1:0] own_master = masters'(1) << master_num;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [width-1:0]    addr_q, addr_d;
    logic [len_bits-1:0] len_q, len_d;
    logic [id_bits-1:0]  id_q, id_d;
    logic [id_bits-1:0]  id_cnt_q, id_cnt_d;
    logic [len_bits:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                beat_last;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            id_cnt_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            id_q     <= id_d;
            id_cnt_q <= id_cnt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        id_d     = id_q;
        id_cnt_d = id_cnt_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        beat_last = (cnt_q == {1'b0, len_q});

        CMD_READY = 1'b0;
        WD_READY  = 1'b0;
        RD_DATA   = '0;
        RD_LAST   = 1'b0;
        RD_VALID  = 1'b0;
        DONE      = 1'b0;
        ERROR     = 1'b0;

        bus.AWMASTER = '0;  bus.AWID    = '0;  bus.AWADDR  = '0;  bus.AWLEN  = '0;
        bus.AWSIZE   = '0;  bus.AWBURST = '0;  bus.AWLOCK  = '0;  bus.AWCACHE = '0;
        bus.AWPROT   = '0;  bus.AWVALID = 1'b0;
        bus.WMASTER  = '0;  bus.WID     = '0;  bus.WDATA   = '0;  bus.WSTRB  = '0;
        bus.WLAST    = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY   = 1'b0;
        bus.ARMASTER = '0;  bus.ARID    = '0;  bus.ARADDR  = '0;  bus.ARLEN  = '0;
        bus.ARSIZE   = '0;  bus.ARBURST = '0;  bus.ARLOCK  = '0;  bus.ARCACHE = '0;
        bus.ARPROT   = '0;  bus.ARVALID = 1'b0;
        bus.RREADY   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated so the command port reads as busy while reset is held
                CMD_READY = ARESETn;
                if (CMD_VALID) begin
                    addr_d   = CMD_ADDR;
                    len_d    = CMD_LEN;
                    id_d     = id_cnt_q;
                    id_cnt_d = id_cnt_q + 1'b1;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = CMD_WRITE ? S_AW : S_AR;
                end
            end
            S_AW: begin
                bus.AWMASTER = own_master;
                bus.AWID     = id_q;
                bus.AWADDR   = addr_q;
                bus.AWLEN    = len_q;
                bus.AWSIZE   = 3'(b_size);
                bus.AWBURST  = 2'b01;
                bus.AWVALID  = 1'b1;
                if (bus.AWREADY) state_d = S_W;
            end
            S_W: begin
                bus.WMASTER = own_master;
                bus.WID     = id_q;
                bus.WDATA   = WD_DATA;
                bus.WSTRB   = WD_STRB;
                bus.WLAST   = beat_last;
                bus.WVALID  = WD_VALID;
                WD_READY    = bus.WREADY;
                if (WD_VALID && bus.WREADY) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) state_d = S_B;
                end
            end
            S_B: begin
                bus.BREADY = 1'b1;
                if (bus.BVALID) begin
                    err_d   = (bus.BRESP != 2'b00) || (bus.BID != id_q) || (bus.BMASTER != own_master);
                    state_d = S_FIN;
                end
            end
            S_AR: begin
                bus.ARMASTER = own_master;
                bus.ARID     = id_q;
                bus.ARADDR   = addr_q;
                bus.ARLEN    = len_q;
                bus.ARSIZE   = 3'(b_size);
                bus.ARBURST  = 2'b01;
                bus.ARVALID  = 1'b1;
                if (bus.ARREADY) state_d = S_R;
            end
            S_R: begin
                RD_VALID   = bus.RVALID;
                RD_DATA    = bus.RDATA;
                RD_LAST    = bus.RLAST;
                bus.RREADY = RD_READY;
                if (bus.RVALID && RD_READY) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((bus.RRESP != 2'b00) || (bus.RID != id_q) ||
                        (bus.RMASTER != own_master) || (bus.RLAST != beat_last))
                        err_d = 1'b1;
                    // A premature RLAST terminates the burst; the flag above reports it
                    if (beat_last || bus.RLAST) state_d = S_FIN;
                end
            end
            S_FIN: begin
                DONE    = 1'b1;
                ERROR   = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_master_if.sv
// tb/tb_axi_master_if.sv - randomized bench for axi_master_if against a transaction-level slave model
module tb_axi_master_if;
    localparam int masters = 4, master_num = 2, width = 16, id_bits = 2, b_size = 3, len_bits = 8;
    localparam logic [3:0] own = 4'b0100;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        CMD_VALID = 1'b0, CMD_WRITE = 1'b0;
    logic [15:0] CMD_ADDR = '0;
    logic [7:0]  CMD_LEN = '0;
    logic [63:0] WD_DATA = '0;
    logic [7:0]  WD_STRB = '0;
    logic        WD_VALID = 1'b0, RD_READY = 1'b0;
    logic        CMD_READY, WD_READY, RD_LAST, RD_VALID, DONE, ERROR;
    logic [63:0] RD_DATA;

    axi_master_if_if #(.masters(masters), .width(width), .id_bits(id_bits), .b_size(b_size), .len_bits(len_bits)) bus ();

    axi_master_if #(.masters(masters), .master_num(master_num), .width(width), .id_bits(id_bits),
                    .b_size(b_size), .len_bits(len_bits)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .WD_DATA(WD_DATA),
        .WD_STRB(WD_STRB), .WD_VALID(WD_VALID), .WD_READY(WD_READY), .RD_DATA(RD_DATA),
        .RD_LAST(RD_LAST), .RD_VALID(RD_VALID), .RD_READY(RD_READY), .DONE(DONE), .ERROR(ERROR),
        .bus(bus)
    );

    always #5 ACLK = ~ACLK;

    int total = 0, bad = 0;
    int exp_id = 0;
    int cur_id = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        CMD_VALID = 0; WD_VALID = 0; RD_READY = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0; bus.BID = 0; bus.BMASTER = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RLAST = 0; bus.RRESP = 0; bus.RID = 0; bus.RMASTER = 0;
        bus.RDATA = 0;
    endtask

    task automatic apply_reset();
        @(negedge ACLK);
        ARESETn = 0;
        clear_inputs();
        @(negedge ACLK); #1;
        check("rst_cmd_ready", CMD_READY, 0);
        check("rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, RD_VALID}, 0);
        check("rst_readys", {bus.BREADY, bus.RREADY, WD_READY}, 0);
        check("rst_done", DONE, 0);
        ARESETn = 1;
        exp_id = 0;
        @(negedge ACLK); #1;
        check("idle_cmd_ready", CMD_READY, 1);
    endtask

    task automatic issue_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len);
        @(negedge ACLK);
        CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_LEN = len;
        #1 check("cmd_ready", CMD_READY, 1);
        cur_id = exp_id;
        exp_id = (exp_id + 1) % (1 << id_bits);
        @(negedge ACLK);
        CMD_VALID = 0;
    endtask

    // bp: 0 = WREADY high, 1 = WREADY low on alternate cycles, 2 = random WD_VALID/WREADY
    task automatic do_write(input logic [15:0] addr, input int len, input int aw_delay, input int bp,
                            input logic [1:0] bresp, input bit bad_bid, input logic [63:0] base);
        logic [63:0] data[$];
        logic [7:0]  strb[$];
        int k, guard;
        bit exp_err;
        for (int i = 0; i <= len; i++) begin
            data.push_back(base != 0 ? base + 64'(i) : {$urandom, $urandom});
            strb.push_back(8'($urandom));
        end
        exp_err = (bresp != 0) || bad_bid;
        issue_cmd(1, addr, 8'(len));
        WD_VALID = 1; WD_DATA = data[0]; bus.WREADY = 1;
        for (int c = 0; c <= aw_delay; c++) begin
            bus.AWREADY = (c == aw_delay);
            #1;
            check("awvalid", bus.AWVALID, 1);
            check("aw_fields", {bus.AWADDR, bus.AWLEN, 6'(bus.AWID), bus.AWSIZE, bus.AWBURST, bus.AWMASTER},
                  {addr, 8'(len), 6'(cur_id), 3'd3, 2'b01, own});
            check("aw_zero_attr", {bus.AWLOCK, bus.AWCACHE, bus.AWPROT}, 0);
            check("w_before_aw", {bus.WVALID, WD_READY}, 0);
            @(negedge ACLK);
        end
        bus.AWREADY = 0;
        #1 check("awvalid_drop", bus.AWVALID, 0);
        k = 0; guard = 0;
        while (k <= len && guard < 2000) begin
            WD_VALID = (bp == 2) ? 1'($urandom) : 1'b1;
            bus.WREADY = (bp == 0) ? 1'b1 : (bp == 1) ? (guard % 2 == 0) : 1'($urandom);
            WD_DATA = data[k]; WD_STRB = strb[k];
            #1;
            check("wvalid", bus.WVALID, WD_VALID);
            check("wd_ready", WD_READY, bus.WREADY);
            check("w_beat", {bus.WDATA, bus.WSTRB, 4'(bus.WID), bus.WMASTER}, {data[k], strb[k], 4'(cur_id), own});
            check("wlast", bus.WLAST, k == len);
            if (WD_VALID && bus.WREADY) k++;
            guard++;
            @(negedge ACLK);
        end
        if (guard >= 2000) check("w_timeout", 0, 1);
        WD_VALID = 0; bus.WREADY = 0;
        for (int c = $urandom_range(0, 2); c > 0; c--) begin
            #1 check("b_wait_bready", bus.BREADY, 1);
            check("b_wait_done", DONE, 0);
            @(negedge ACLK);
        end
        bus.BVALID = 1; bus.BRESP = bresp; bus.BMASTER = own;
        bus.BID = bad_bid ? 2'(cur_id + 1) : 2'(cur_id);
        #1 check("bready", bus.BREADY, 1);
        check("done_early", DONE, 0);
        @(negedge ACLK);
        bus.BVALID = 0;
        #1 check("wr_done", DONE, 1);
        check("wr_error", ERROR, exp_err);
        @(negedge ACLK); #1;
        check("wr_done_pulse", DONE, 0);
        check("wr_back_idle", CMD_READY, 1);
    endtask

    // mode: 0 = RD_READY high, 1 = RD_READY toggles 1/0, 2 = random RVALID/RD_READY
    task automatic do_read(input logic [15:0] addr, input int len, input int ar_delay, input int early,
                           input bit bad_rid, input logic [1:0] rresp, input int mode, input logic [63:0] base);
        logic [63:0] data[$];
        logic [63:0] got[$];
        int j, guard, last;
        bit exp_err;
        last = (early >= 0) ? early : len;
        for (int i = 0; i <= last; i++) data.push_back(base != 0 ? base + 64'(i) : {$urandom, $urandom});
        exp_err = (early >= 0) || bad_rid || (rresp != 0);
        issue_cmd(0, addr, 8'(len));
        RD_READY = 1;
        for (int c = 0; c <= ar_delay; c++) begin
            bus.ARREADY = (c == ar_delay);
            #1;
            check("arvalid", bus.ARVALID, 1);
            check("ar_fields", {bus.ARADDR, bus.ARLEN, 6'(bus.ARID), bus.ARSIZE, bus.ARBURST, bus.ARMASTER},
                  {addr, 8'(len), 6'(cur_id), 3'd3, 2'b01, own});
            check("ar_zero_attr", {bus.ARLOCK, bus.ARCACHE, bus.ARPROT}, 0);
            check("r_before_ar", {bus.RREADY, bus.AWVALID}, 0);
            @(negedge ACLK);
        end
        bus.ARREADY = 0;
        #1 check("arvalid_drop", bus.ARVALID, 0);
        j = 0; guard = 0;
        while (j <= last && guard < 2000) begin
            bus.RVALID = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            RD_READY = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom);
            bus.RDATA = data[j]; bus.RLAST = (j == last); bus.RRESP = rresp; bus.RMASTER = own;
            bus.RID = bad_rid ? 2'(cur_id + 1) : 2'(cur_id);
            #1;
            check("rd_valid", RD_VALID, bus.RVALID);
            check("rready", bus.RREADY, RD_READY);
            if (bus.RVALID) check("rd_beat", {RD_DATA, 7'd0, RD_LAST}, {data[j], 7'd0, j == last});
            if (RD_VALID && RD_READY) got.push_back(RD_DATA);
            if (bus.RVALID && bus.RREADY) j++;
            guard++;
            @(negedge ACLK);
        end
        if (guard >= 2000) check("r_timeout", 0, 1);
        bus.RVALID = 0; bus.RLAST = 0; RD_READY = 0;
        check("rd_count", got.size(), last + 1);
        foreach (got[i]) if (i <= last) check("rd_seq", got[i], data[i]);
        #1 check("rd_done", DONE, 1);
        check("rd_error", ERROR, exp_err);
        @(negedge ACLK); #1;
        check("rd_done_pulse", DONE, 0);
        check("rd_back_idle", CMD_READY, 1);
    endtask

    initial begin
        int len, early;
        clear_inputs();
        apply_reset();

        do_write(16'h0040, 3, 0, 0, 2'b00, 0, 64'hD0);
        do_read(16'h0100, 1, 0, -1, 0, 2'b00, 1, 64'hA);
        do_write(16'h0200, 3, 5, 1, 2'b00, 0, 0);
        do_write(16'h0300, 2, 0, 0, 2'b10, 0, 0);
        do_read(16'h0400, 3, 0, 0, 0, 2'b00, 0, 0);
        do_read(16'h0500, 2, 1, -1, 1, 2'b00, 0, 0);
        do_write(16'h0600, 0, 0, 0, 2'b00, 1, 0);

        apply_reset();
        for (int i = 0; i < 5; i++) do_read(16'h0800 + 16'(8 * i), i % 2, 0, -1, 0, 2'b00, 0, 0);

        for (int i = 0; i < 20; i++) begin
            len = (i == 0) ? 255 : (i == 1) ? 0 : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1)
                do_write(16'($urandom) & 16'hFFF8, len, $urandom_range(0, 3), 2,
                         ($urandom_range(0, 4) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'b00,
                         $urandom_range(0, 6) == 0, 0);
            else begin
                early = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
                do_read(16'($urandom) & 16'hFFF8, len, $urandom_range(0, 3), early,
                        $urandom_range(0, 6) == 0,
                        ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00, 2, 0);
            end
        end

        // Reset lands while beat 3 of a 4-beat write is pending
        issue_cmd(1, 16'h0A00, 8'd3);
        bus.AWREADY = 1;
        @(negedge ACLK);
        bus.AWREADY = 0; bus.WREADY = 1;
        for (int b = 0; b < 2; b++) begin
            WD_VALID = 1; WD_DATA = 64'(b);
            @(negedge ACLK);
        end
        ARESETn = 0;
        @(negedge ACLK); #1;
        check("midrst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, RD_VALID}, 0);
        check("midrst_cmd_ready", CMD_READY, 0);
        check("midrst_done", DONE, 0);
        ARESETn = 1;
        clear_inputs();
        exp_id = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK); #1;
            check("postrst_no_done", DONE, 0);
            check("postrst_cmd_ready", CMD_READY, 1);
        end
        do_write(16'h0B00, 3, 0, 0, 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
